// File: rtl/cnt_seq_monitor_if.sv
// Connection bundle between the 3-bit sequence counter stream and its monitor.
// The master side drives cnt; the slave (the monitor) returns decoded status.
interface cnt_seq_monitor_if #(
   parameter int unsigned LAP_W = 8
);
   logic [2:0]       cnt;
   logic [2:0]       pos;
   logic             locked;
   logic             err;
   logic [7:0]       err_cnt;
   logic [LAP_W-1:0] laps;

   modport master (
      output cnt,
      input  pos, locked, err, err_cnt, laps
   );

   modport slave (
      input  cnt,
      output pos, locked, err, err_cnt, laps
   );
endinterface

// File: rtl/cnt_seq_monitor.sv
// Checker for the 000->011->110->001->100 counter: decodes each sample to an ordinal,
// locks after RESYNC good transitions, and counts laps and errors while locked.
module cnt_seq_monitor #(
   parameter int unsigned LAP_W  = 8,
   parameter int unsigned RESYNC = 2
) (
   input logic              clk,
   input logic              reset,
   cnt_seq_monitor_if.slave mon
);

   localparam int unsigned      RunW    = $clog2(RESYNC + 1);
   localparam logic [RunW:0]    ResyncV = (RunW + 1)'(RESYNC);
   localparam logic [RunW:0]    RunOne  = (RunW + 1)'(1);
   localparam logic [LAP_W-1:0] LapOne  = LAP_W'(1);

   typedef enum logic {StUnlocked, StLocked} state_e;

   state_e           state_q, state_d;
   logic [RunW-1:0]  run_q, run_d;
   logic [RunW:0]    run_inc;
   logic [2:0]       prev_q, prev_d;
   logic             prev_valid_q, prev_valid_d;
   logic [2:0]       pos_q, pos_d;
   logic             err_q, err_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic [LAP_W-1:0] laps_q, laps_d;
   logic             cnt_legal;
   logic             good;

   // Ordinal position within the legal cycle; 7 marks any code outside it.
   function automatic logic [2:0] ord_of(input logic [2:0] c);
      case (c)
         3'b000:  return 3'd0;
         3'b011:  return 3'd1;
         3'b110:  return 3'd2;
         3'b001:  return 3'd3;
         3'b100:  return 3'd4;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic [2:0] succ_of(input logic [2:0] c);
      case (c)
         3'b000:  return 3'b011;
         3'b011:  return 3'b110;
         3'b110:  return 3'b001;
         3'b001:  return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StUnlocked;
         run_q        <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         pos_q        <= 3'd7;
         err_q        <= 1'b0;
         err_cnt_q    <= '0;
         laps_q       <= '0;
      end else begin
         state_q      <= state_d;
         run_q        <= run_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         pos_q        <= pos_d;
         err_q        <= err_d;
         err_cnt_q    <= err_cnt_d;
         laps_q       <= laps_d;
      end
   end

   always_comb begin
      cnt_legal    = (ord_of(mon.cnt) != 3'd7);
      // A hold never matches succ_of(prev), so it is rejected here as well.
      good         = prev_valid_q & cnt_legal & (mon.cnt == succ_of(prev_q));
      run_inc      = {1'b0, run_q} + RunOne;
      state_d      = state_q;
      run_d        = run_q;
      prev_d       = mon.cnt;
      prev_valid_d = cnt_legal;
      pos_d        = ord_of(mon.cnt);
      err_d        = 1'b0;
      err_cnt_d    = err_cnt_q;
      laps_d       = laps_q;

      unique case (state_q)
         StUnlocked: begin
            if (good) begin
               // Locking on a 100->000 edge deliberately does not count a lap.
               if (run_inc == ResyncV) begin
                  state_d = StLocked;
                  run_d   = '0;
               end else begin
                  run_d = run_inc[RunW-1:0];
               end
            end else begin
               run_d = '0;
            end
         end
         StLocked: begin
            if (good) begin
               if (prev_q == 3'b100) begin
                  laps_d = laps_q + LapOne;
               end
            end else begin
               err_d   = 1'b1;
               state_d = StUnlocked;
               run_d   = '0;
               if (err_cnt_q != 8'hff) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = StUnlocked;
            run_d   = '0;
         end
      endcase
   end

   assign mon.pos     = pos_q;
   assign mon.locked  = (state_q == StLocked);
   assign mon.err     = err_q;
   assign mon.err_cnt = err_cnt_q;
   assign mon.laps    = laps_q;

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Bench for cnt_seq_monitor: directed vector table, corner sequences, then random stream
// against an ordinal-arithmetic reference model. Two DUTs share stimulus (LAP_W 8 and 2).
module tb_cnt_seq_monitor;

   localparam int unsigned RESYNC = 2;

   typedef struct packed {
      logic       rst;
      logic [2:0] c;
      logic [2:0] pos;
      logic       lk;
      logic       er;
      logic [7:0] ec;
      logic [7:0] lp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] cnt = 3'b000;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state, in ordinal terms
   int ord_tab[8];
   int code_tab[5];
   int m_prev, m_pos, m_streak, m_errcnt, m_laps;
   bit m_locked, m_err;

   vec_t tbl[$];

   always #5 clk = ~clk;

   cnt_seq_monitor_if #(.LAP_W(8)) if8 ();
   cnt_seq_monitor_if #(.LAP_W(2)) if2 ();

   assign if8.cnt = cnt;
   assign if2.cnt = cnt;

   cnt_seq_monitor #(.LAP_W(8), .RESYNC(RESYNC)) dut8 (
      .clk   (clk),
      .reset (reset),
      .mon   (if8)
   );

   cnt_seq_monitor #(.LAP_W(2), .RESYNC(RESYNC)) dut2 (
      .clk   (clk),
      .reset (reset),
      .mon   (if2)
   );

   task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic model_update(input logic r, input logic [2:0] c);
      int  o;
      bit  good;
      if (r) begin
         m_prev = 7; m_pos = 7; m_streak = 0; m_errcnt = 0; m_laps = 0;
         m_locked = 1'b0; m_err = 1'b0;
      end else begin
         o    = ord_tab[c];
         good = (m_prev != 7) && (o != 7) && (o == (m_prev + 1) % 5);
         m_err = 1'b0;
         if (!m_locked) begin
            if (good) begin
               m_streak++;
               if (m_streak == RESYNC) begin
                  m_locked = 1'b1;
                  m_streak = 0;
               end
            end else begin
               m_streak = 0;
            end
         end else if (good) begin
            if (m_prev == 4) m_laps++;
         end else begin
            m_err = 1'b1;
            if (m_errcnt < 255) m_errcnt++;
            m_locked = 1'b0;
            m_streak = 0;
         end
         m_prev = o;
         m_pos  = o;
      end
   endtask

   task automatic check_model(input string tag);
      expect_val({tag, "_pos"},    32'(if8.pos),     32'(m_pos));
      expect_val({tag, "_locked"}, 32'(if8.locked),  32'(m_locked));
      expect_val({tag, "_err"},    32'(if8.err),     32'(m_err));
      expect_val({tag, "_errcnt"}, 32'(if8.err_cnt), 32'(m_errcnt));
      expect_val({tag, "_laps8"},  32'(if8.laps),    32'(m_laps % 256));
      expect_val({tag, "_laps2"},  32'(if2.laps),    32'(m_laps % 4));
      expect_val({tag, "_lk2"},    32'(if2.locked),  32'(m_locked));
   endtask

   // Drive one sample away from the edge, clock it, then compare 1 time unit later.
   task automatic step(input logic r, input logic [2:0] c, input string tag);
      @(negedge clk);
      reset = r;
      cnt   = c;
      @(posedge clk);
      model_update(r, c);
      #1;
      check_model(tag);
   endtask

   initial begin
      logic [2:0]  last_c;
      logic [2:0]  c;
      logic        r;
      int unsigned rr;

      ord_tab  = '{0, 3, 7, 1, 4, 7, 2, 7};
      code_tab = '{0, 3, 6, 1, 4};
      model_update(1'b1, 3'b000);

      //            rst   cnt     pos  lk  er  err_cnt laps
      tbl.push_back({1'b1, 3'b000, 3'd7, 1'b0, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b000, 3'd0, 1'b0, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b011, 3'd1, 1'b0, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b110, 3'd2, 1'b1, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b001, 3'd3, 1'b1, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b100, 3'd4, 1'b1, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b000, 3'd0, 1'b1, 1'b0, 8'd0, 8'd1});
      tbl.push_back({1'b0, 3'b010, 3'd7, 1'b0, 1'b1, 8'd1, 8'd1});
      tbl.push_back({1'b0, 3'b011, 3'd1, 1'b0, 1'b0, 8'd1, 8'd1});
      tbl.push_back({1'b0, 3'b110, 3'd2, 1'b0, 1'b0, 8'd1, 8'd1});
      tbl.push_back({1'b0, 3'b001, 3'd3, 1'b1, 1'b0, 8'd1, 8'd1});
      tbl.push_back({1'b0, 3'b100, 3'd4, 1'b1, 1'b0, 8'd1, 8'd1});
      tbl.push_back({1'b0, 3'b000, 3'd0, 1'b1, 1'b0, 8'd1, 8'd2});
      tbl.push_back({1'b0, 3'b011, 3'd1, 1'b1, 1'b0, 8'd1, 8'd2});
      tbl.push_back({1'b0, 3'b011, 3'd1, 1'b0, 1'b1, 8'd2, 8'd2});
      tbl.push_back({1'b0, 3'b011, 3'd1, 1'b0, 1'b0, 8'd2, 8'd2});
      tbl.push_back({1'b0, 3'b110, 3'd2, 1'b0, 1'b0, 8'd2, 8'd2});
      tbl.push_back({1'b0, 3'b001, 3'd3, 1'b1, 1'b0, 8'd2, 8'd2});
      tbl.push_back({1'b1, 3'b100, 3'd7, 1'b0, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b100, 3'd4, 1'b0, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b000, 3'd0, 1'b0, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b011, 3'd1, 1'b1, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b1, 3'b001, 3'd7, 1'b0, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b001, 3'd3, 1'b0, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b100, 3'd4, 1'b0, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b000, 3'd0, 1'b1, 1'b0, 8'd0, 8'd0});
      tbl.push_back({1'b0, 3'b011, 3'd1, 1'b1, 1'b0, 8'd0, 8'd0});

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].c, $sformatf("row%0d_model", i));
         expect_val($sformatf("row%0d_pos", i),    32'(if8.pos),     32'(tbl[i].pos));
         expect_val($sformatf("row%0d_locked", i), 32'(if8.locked),  32'(tbl[i].lk));
         expect_val($sformatf("row%0d_err", i),    32'(if8.err),     32'(tbl[i].er));
         expect_val($sformatf("row%0d_errcnt", i), 32'(if8.err_cnt), 32'(tbl[i].ec));
         expect_val($sformatf("row%0d_laps", i),   32'(if8.laps),    32'(tbl[i].lp));
      end

      // Four locked laps: the 2-bit lap counter must read 1,2,3,0
      for (int k = 1; k <= 4; k++) begin
         step(1'b0, 3'b110, "t5");
         step(1'b0, 3'b001, "t5");
         step(1'b0, 3'b100, "t5");
         step(1'b0, 3'b000, "t5");
         expect_val($sformatf("t5_lap%0d_laps2", k), 32'(if2.laps), 32'(k % 4));
         expect_val($sformatf("t5_lap%0d_laps8", k), 32'(if8.laps), 32'(k));
         step(1'b0, 3'b011, "t5");
      end

      // 260 error/relock episodes: err_cnt saturates while err keeps pulsing
      for (int k = 0; k < 260; k++) begin
         step(1'b0, 3'b010, "t6");
         expect_val($sformatf("t6_ep%0d_err", k), 32'(if8.err), 32'd1);
         step(1'b0, 3'b000, "t6");
         step(1'b0, 3'b011, "t6");
         step(1'b0, 3'b110, "t6");
         expect_val($sformatf("t6_ep%0d_relock", k), 32'(if8.locked), 32'd1);
      end
      expect_val("t6_errcnt_sat", 32'(if8.err_cnt), 32'd255);
      step(1'b0, 3'b111, "t6_post");
      expect_val("t6_post_err", 32'(if8.err), 32'd1);
      expect_val("t6_post_errcnt", 32'(if8.err_cnt), 32'd255);

      // Random stream: mostly legal successors, with holds, junk codes and rare resets
      last_c = 3'b111;
      for (int i = 0; i < 3000; i++) begin
         rr = $urandom_range(0, 199);
         r  = (rr == 0);
         if (rr < 176) begin
            if (ord_tab[last_c] == 7) c = 3'b000;
            else c = 3'(code_tab[(ord_tab[last_c] + 1) % 5]);
         end else if (rr < 188) begin
            c = last_c;
         end else begin
            c = 3'($urandom_range(0, 7));
         end
         step(r, c, "rand");
         last_c = c;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
